// File: rtl/idecode_pipe_if.sv
// Bus bundle for the decode stage: fetch-side offer, writeback port, and the ID/EX slot.
// Handshake: a fetch word transfers on a rising edge when if_valid & if_ready & !flush; the slot
// transfers to execute when id_valid & ex_ready. Neither side may depend on the other's ready
// to raise its valid.
interface idecode_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instruction;
  logic [DATA_W-1:0] if_pc_plus4;
  logic              flush;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_ready;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm_ext;
  logic [ADDR_W-1:0] id_dest_addr;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [DATA_W-1:0] id_pc_plus4;

  modport master (
    output if_valid, if_instruction, if_pc_plus4, flush,
    output wb_reg_write, wb_addr, wb_data, ex_ready,
    input  if_ready, id_valid, id_rs_data, id_rt_data, id_imm_ext,
    input  id_dest_addr, id_opcode, id_funct, id_pc_plus4
  );

  modport slave (
    input  if_valid, if_instruction, if_pc_plus4, flush,
    input  wb_reg_write, wb_addr, wb_data, ex_ready,
    output if_ready, id_valid, id_rs_data, id_rt_data, id_imm_ext,
    output id_dest_addr, id_opcode, id_funct, id_pc_plus4
  );
endinterface

// File: rtl/idecode_pipe.sv
// Instruction-decode stage: 2R/1W register file with writeback bypass, immediate extend,
// destination select and a registered ID/EX slot that refreshes its operands while stalled.
module idecode_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_NUM    = 32,
  parameter int RESET_INIT = 0,
  parameter int LINK_REG   = 31
) (
  input  logic          clock,
  input  logic          reset,
  idecode_pipe_if.slave bus
);
   localparam int ADDR_W = $clog2(REG_NUM);

   logic [DATA_W-1:0] regs_q [REG_NUM];

   logic [31:0]       instr;
   logic [5:0]        opcode;
   logic [ADDR_W-1:0] rs_f, rt_f, rd_f;
   logic              wb_we, accept, zext;
   logic [DATA_W-1:0] rs_rd, rt_rd, imm_ext;
   logic [ADDR_W-1:0] dest;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q, imm_d, pc_q, pc_d;
   logic [ADDR_W-1:0] dest_q, dest_d, rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
   logic [5:0]        opcode_q, opcode_d, funct_q, funct_d;

   assign instr  = bus.if_instruction;
   assign opcode = instr[31:26];
   // Register fields keep only their low ADDR_W bits for smaller register files.
   assign rs_f   = instr[21 +: ADDR_W];
   assign rt_f   = instr[16 +: ADDR_W];
   assign rd_f   = instr[11 +: ADDR_W];

   assign wb_we  = bus.wb_reg_write && (bus.wb_addr != '0);
   assign rs_rd  = (rs_f == '0) ? '0 : (wb_we && bus.wb_addr == rs_f) ? bus.wb_data : regs_q[rs_f];
   assign rt_rd  = (rt_f == '0) ? '0 : (wb_we && bus.wb_addr == rt_f) ? bus.wb_data : regs_q[rt_f];

   always_comb begin
      zext = 1'b0;
      case (opcode)
         6'b001100, 6'b001101, 6'b001110, 6'b001011: zext = 1'b1;
         default:                                    zext = 1'b0;
      endcase
   end

   assign imm_ext = zext ? DATA_W'(instr[15:0]) : DATA_W'($signed(instr[15:0]));

   always_comb begin
      case (opcode)
         6'b000000: dest = rd_f;
         6'b000011: dest = ADDR_W'(LINK_REG);
         default:   dest = rt_f;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= (RESET_INIT != 0) ? DATA_W'(i) : '0;
         end
      end else if (wb_we) begin
         regs_q[bus.wb_addr] <= bus.wb_data;
      end
   end

   assign bus.if_ready = !valid_q || bus.ex_ready;
   assign accept       = bus.if_valid && bus.if_ready && !bus.flush;

   always_comb begin
      valid_d   = valid_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      pc_d      = pc_q;
      dest_d    = dest_q;
      rs_addr_d = rs_addr_q;
      rt_addr_d = rt_addr_q;
      opcode_d  = opcode_q;
      funct_d   = funct_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         rs_data_d = rs_rd;
         rt_data_d = rt_rd;
         imm_d     = imm_ext;
         pc_d      = bus.if_pc_plus4;
         dest_d    = dest;
         rs_addr_d = rs_f;
         rt_addr_d = rt_f;
         opcode_d  = opcode;
         funct_d   = instr[5:0];
      end else if (bus.ex_ready) begin
         valid_d = 1'b0;
      end else if (valid_q) begin
         // Stalled: pick up a writeback that targets an operand already captured in the slot.
         if (wb_we && bus.wb_addr == rs_addr_q) rs_data_d = bus.wb_data;
         if (wb_we && bus.wb_addr == rt_addr_q) rt_data_d = bus.wb_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc_q      <= '0;
         dest_q    <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         opcode_q  <= '0;
         funct_q   <= '0;
      end else begin
         valid_q   <= valid_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         pc_q      <= pc_d;
         dest_q    <= dest_d;
         rs_addr_q <= rs_addr_d;
         rt_addr_q <= rt_addr_d;
         opcode_q  <= opcode_d;
         funct_q   <= funct_d;
      end
   end

   assign bus.id_valid     = valid_q;
   assign bus.id_rs_data   = rs_data_q;
   assign bus.id_rt_data   = rt_data_q;
   assign bus.id_imm_ext   = imm_q;
   assign bus.id_dest_addr = dest_q;
   assign bus.id_opcode    = opcode_q;
   assign bus.id_funct     = funct_q;
   assign bus.id_pc_plus4  = pc_q;
endmodule
